// File: rtl/riscv_decoder_gpr_issue_if.sv
// Bundle interface between fetch/align, the GPR decode/issue register and
// the operand-read stage.
//   in_*   : decode bundle from fetch/align (valid/ready)
//   out_*  : registered decode results to operand read (valid/ready)
//   wb_*   : writeback retire, clears a scoreboard bit
//   flush  : synchronous pipeline flush
// slave  = the decoder, master = the surrounding pipeline / bench.
interface riscv_decoder_gpr_issue_if #(
  parameter int NUM_LANES = 2
) ();
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_LANES-1:0][31:0]     in_instr;
  logic [NUM_LANES-1:0]           in_compressed;
  logic [NUM_LANES-1:0]           in_lane_valid;

  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_LANES-1:0][4:0]      out_rd_addr;
  logic [NUM_LANES-1:0][4:0]      out_rs1_addr;
  logic [NUM_LANES-1:0][4:0]      out_rs2_addr;
  logic [NUM_LANES-1:0]           out_rd_we;
  logic [NUM_LANES-1:0]           out_rs1_used;
  logic [NUM_LANES-1:0]           out_rs2_used;
  logic [NUM_LANES-1:0]           out_lane_valid;
  logic [NUM_LANES-1:0]           out_intra_raw;
  logic [NUM_LANES-1:0]           out_illegal_reg;

  logic                           wb_valid;
  logic [4:0]                     wb_addr;
  logic                           flush;

  modport slave (
    input  in_valid, in_instr, in_compressed, in_lane_valid,
    output in_ready,
    output out_valid, out_rd_addr, out_rs1_addr, out_rs2_addr, out_rd_we,
           out_rs1_used, out_rs2_used, out_lane_valid, out_intra_raw,
           out_illegal_reg,
    input  out_ready,
    input  wb_valid, wb_addr, flush
  );

  modport master (
    output in_valid, in_instr, in_compressed, in_lane_valid,
    input  in_ready,
    input  out_valid, out_rd_addr, out_rs1_addr, out_rs2_addr, out_rd_we,
           out_rs1_used, out_rs2_used, out_lane_valid, out_intra_raw,
           out_illegal_reg,
    output out_ready,
    output wb_valid, wb_addr, flush
  );
endinterface

// File: rtl/riscv_decoder_gpr_issue.sv
// Multi-lane registered RV32/RVC GPR address decoder with an in-flight
// destination scoreboard and RAW/WAW issue stall.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : riscv_decoder_gpr_issue_if.slave (in/out handshakes,
//                writeback retire, flush)
// Lane k of in_instr is decoded by its own lane decoder; results are
// latched on acceptance and presented with 1-cycle latency.

// Single-lane combinational decoder. Invalid lanes decode to all zeros.
//   instr_i/compressed_i/valid_i : one lane of the input bundle
//   rd_o/rs1_o/rs2_o             : register addresses
//   rd_we_o/rs1_used_o/rs2_used_o: write / read flags
module riscv_decoder_gpr_issue_lane (
  input  logic [31:0] instr_i,
  input  logic        compressed_i,
  input  logic        valid_i,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        rd_we_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o
);
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_AMO     = 7'b0101111;

  logic [6:0] opc;
  logic [2:0] f3, cf3;
  logic [4:0] c42, c97, c62, r117;
  logic [4:0] rd, rs1, rs2;
  logic       we, u1, u2;

  assign opc  = instr_i[6:0];
  assign f3   = instr_i[14:12];
  assign cf3  = instr_i[15:13];
  assign c42  = {2'b01, instr_i[9:7]};
  assign c97  = {2'b01, instr_i[4:2]};
  assign c62  = instr_i[6:2];
  assign r117 = instr_i[11:7];

  always_comb begin
    rd = '0; rs1 = '0; rs2 = '0;
    we = 1'b0; u1 = 1'b0; u2 = 1'b0;
    if (!compressed_i) begin
      rd  = instr_i[11:7];
      rs1 = instr_i[19:15];
      rs2 = instr_i[24:20];
      we  = 1'b1;
      if (opc inside {OP_BRANCH, OP_STORE, OP_MISCMEM} ||
          (opc == OP_SYSTEM && f3 == 3'b000))
        we = 1'b0;
      u1 = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
      u2 = opc inside {OP_OP, OP_STORE, OP_BRANCH, OP_AMO};
    end else begin
      case ({instr_i[1:0], cf3})
        5'b00_000: begin rd = c97; rs1 = 5'd2; we = 1'b1; u1 = 1'b1; end   // ADDI4SPN
        5'b00_010: begin rd = c97; rs1 = c42;  we = 1'b1; u1 = 1'b1; end   // LW
        5'b00_110: begin rs1 = c42; rs2 = c97; u1 = 1'b1; u2 = 1'b1; end   // SW
        5'b01_000: begin rd = r117; rs1 = r117; we = 1'b1; u1 = 1'b1; end  // ADDI/NOP
        5'b01_001: begin rd = 5'd1; we = 1'b1; end                         // JAL
        5'b01_010: begin rd = r117; we = 1'b1; end                         // LI
        5'b01_011: begin
          if (r117 == 5'd2) begin rd = 5'd2; rs1 = 5'd2; we = 1'b1; u1 = 1'b1; end  // ADDI16SP
          else begin rd = r117; we = 1'b1; end                                      // LUI
        end
        5'b01_100: begin
          if (instr_i[11:10] != 2'b11) begin                               // SRLI/SRAI/ANDI
            rd = c42; rs1 = c42; we = 1'b1; u1 = 1'b1;
          end else if (!instr_i[12]) begin                                 // SUB/XOR/OR/AND
            rd = c42; rs1 = c42; rs2 = c97; we = 1'b1; u1 = 1'b1; u2 = 1'b1;
          end
        end
        5'b01_110, 5'b01_111: begin rs1 = c42; u1 = 1'b1; end              // BEQZ/BNEZ
        5'b10_000: begin rd = r117; rs1 = r117; we = 1'b1; u1 = 1'b1; end  // SLLI
        5'b10_010: begin rd = r117; rs1 = 5'd2; we = 1'b1; u1 = 1'b1; end  // LWSP
        5'b10_100: begin
          if (!instr_i[12]) begin
            if (c62 == 5'd0) begin rs1 = r117; u1 = 1'b1; end              // JR
            else begin rd = r117; rs2 = c62; we = 1'b1; u2 = 1'b1; end     // MV
          end else if (c62 == 5'd0) begin
            if (r117 != 5'd0) begin rd = 5'd1; rs1 = r117; we = 1'b1; u1 = 1'b1; end  // JALR
          end else begin                                                   // ADD
            rd = r117; rs1 = r117; rs2 = c62; we = 1'b1; u1 = 1'b1; u2 = 1'b1;
          end
        end
        5'b10_110: begin rs1 = 5'd2; rs2 = c62; u1 = 1'b1; u2 = 1'b1; end  // SWSP
        default: ;
      endcase
      // x0 is never a real RVC operand
      u1 = u1 && (rs1 != 5'd0);
      u2 = u2 && (rs2 != 5'd0);
    end
    we = we && (rd != 5'd0);
    if (!valid_i) begin
      rd = '0; rs1 = '0; rs2 = '0;
      we = 1'b0; u1 = 1'b0; u2 = 1'b0;
    end
  end

  assign rd_o       = rd;
  assign rs1_o      = rs1;
  assign rs2_o      = rs2;
  assign rd_we_o    = we;
  assign rs1_used_o = u1;
  assign rs2_used_o = u2;
endmodule

module riscv_decoder_gpr_issue #(
  parameter int NUM_LANES = 2,
  parameter int NUM_GPR   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  riscv_decoder_gpr_issue_if.slave bus
);
  localparam bit RV32E = (NUM_GPR == 16);

  logic [NUM_LANES-1:0][4:0] d_rd, d_rs1, d_rs2;
  logic [NUM_LANES-1:0]      d_we, d_u1, d_u2, d_intra, d_ill;

  logic [NUM_LANES-1:0][4:0] rd_q, rs1_q, rs2_q;
  logic [NUM_LANES-1:0]      we_q, u1_q, u2_q, lv_q, intra_q, ill_q;
  logic                      out_valid_q;

  logic [NUM_GPR-1:0]        sb_q, sb_d;
  logic [31:0]               sb_ext, sb_set, sb_clr, sb_nxt;
  logic                      hazard, accept;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    riscv_decoder_gpr_issue_lane u_lane (
      .instr_i     (bus.in_instr[k]),
      .compressed_i(bus.in_compressed[k]),
      .valid_i     (bus.in_lane_valid[k]),
      .rd_o        (d_rd[k]),
      .rs1_o       (d_rs1[k]),
      .rs2_o       (d_rs2[k]),
      .rd_we_o     (d_we[k]),
      .rs1_used_o  (d_u1[k]),
      .rs2_used_o  (d_u2[k])
    );
  end

  // Zero-extended view so any 5-bit address indexes safely; addresses
  // beyond NUM_GPR read as "not in flight".
  assign sb_ext = 32'(sb_q);

  always_comb begin
    d_intra = '0;
    d_ill   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      for (int j = 0; j < k; j++) begin
        if (d_we[j] && ((d_u1[k] && d_rs1[k] == d_rd[j]) ||
                        (d_u2[k] && d_rs2[k] == d_rd[j])))
          d_intra[k] = 1'b1;
      end
      d_ill[k] = RV32E && ((d_we[k] && d_rd[k][4]) ||
                           (d_u1[k] && d_rs1[k][4]) ||
                           (d_u2[k] && d_rs2[k][4]));
    end
  end

  // Stall from the registered scoreboard only; no writeback bypass.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if ((d_u1[k] && sb_ext[d_rs1[k]]) ||
          (d_u2[k] && sb_ext[d_rs2[k]]) ||
          (d_we[k] && sb_ext[d_rd[k]]))
        hazard = 1'b1;
    end
  end

  assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Set is OR-ed after clear so an accept-time set beats a same-cycle retire.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (accept) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (d_we[k]) sb_set[d_rd[k]] = 1'b1;
    end
    if (bus.wb_valid) sb_clr[bus.wb_addr] = 1'b1;
    sb_nxt = (sb_ext & ~sb_clr) | sb_set;
    sb_d   = bus.flush ? '0 : sb_nxt[NUM_GPR-1:0];
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      we_q        <= '0;
      u1_q        <= '0;
      u2_q        <= '0;
      lv_q        <= '0;
      intra_q     <= '0;
      ill_q       <= '0;
    end else begin
      sb_q <= sb_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        rd_q        <= d_rd;
        rs1_q       <= d_rs1;
        rs2_q       <= d_rs2;
        we_q        <= d_we;
        u1_q        <= d_u1;
        u2_q        <= d_u2;
        lv_q        <= bus.in_lane_valid;
        intra_q     <= d_intra;
        ill_q       <= d_ill;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_rd_addr     = rd_q;
  assign bus.out_rs1_addr    = rs1_q;
  assign bus.out_rs2_addr    = rs2_q;
  assign bus.out_rd_we       = we_q;
  assign bus.out_rs1_used    = u1_q;
  assign bus.out_rs2_used    = u2_q;
  assign bus.out_lane_valid  = lv_q;
  assign bus.out_intra_raw   = intra_q;
  assign bus.out_illegal_reg = ill_q;
endmodule

// File: tb/tb_riscv_decoder_gpr_issue.sv
// Directed bench for riscv_decoder_gpr_issue: a 2-lane RV32I instance
// (ifa/dut) checked through an expected-result queue, plus a 2-lane RV32E
// instance (ife/dut_e) for the illegal-register flag.
module tb_riscv_decoder_gpr_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_decoder_gpr_issue_if #(.NUM_LANES(2)) ifa ();
  riscv_decoder_gpr_issue_if #(.NUM_LANES(2)) ife ();

  riscv_decoder_gpr_issue #(.NUM_LANES(2), .NUM_GPR(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  riscv_decoder_gpr_issue #(.NUM_LANES(2), .NUM_GPR(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(ife));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] rd, rs1, rs2;
    logic [1:0] we, u1, u2, lv, intra, ill;
  } exp_t;
  exp_t q[$];

  function automatic exp_t mk(input logic [4:0] rd1, rs11, rs21, rd0, rs10, rs20,
                              input logic [1:0] we, u1, u2, lv, intra, ill);
    exp_t e;
    e.rd = {rd1, rd0}; e.rs1 = {rs11, rs10}; e.rs2 = {rs21, rs20};
    e.we = we; e.u1 = u1; e.u2 = u2; e.lv = lv; e.intra = intra; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i1, i0, input logic [1:0] c, lv);
    ifa.in_valid      = 1'b1;
    ifa.in_instr      = {i1, i0};
    ifa.in_compressed = c;
    ifa.in_lane_valid = lv;
  endtask

  task automatic idle();
    ifa.in_valid      = 1'b0;
    ifa.in_instr      = '0;
    ifa.in_compressed = '0;
    ifa.in_lane_valid = '0;
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".rd"},    32'(ifa.out_rd_addr),     32'(e.rd));
    chk({tag, ".rs1"},   32'(ifa.out_rs1_addr),    32'(e.rs1));
    chk({tag, ".rs2"},   32'(ifa.out_rs2_addr),    32'(e.rs2));
    chk({tag, ".we"},    32'(ifa.out_rd_we),       32'(e.we));
    chk({tag, ".u1"},    32'(ifa.out_rs1_used),    32'(e.u1));
    chk({tag, ".u2"},    32'(ifa.out_rs2_used),    32'(e.u2));
    chk({tag, ".lv"},    32'(ifa.out_lane_valid),  32'(e.lv));
    chk({tag, ".intra"}, 32'(ifa.out_intra_raw),   32'(e.intra));
    chk({tag, ".ill"},   32'(ifa.out_illegal_reg), 32'(e.ill));
  endtask

  task automatic pop_out(input string tag);
    chk({tag, ".out_valid"}, 32'(ifa.out_valid), 32'd1);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=pending_result", tag);
    end else begin
      cmp_out(tag, q.pop_front());
    end
  endtask

  task automatic wb(input logic [4:0] a);
    ifa.wb_valid = 1'b1;
    ifa.wb_addr  = a;
    tick();
    ifa.wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    ifa.out_ready = 1'b1; ifa.wb_valid = 1'b0; ifa.wb_addr = '0; ifa.flush = 1'b0;
    ife.in_valid = 1'b0; ife.in_instr = '0; ife.in_compressed = '0; ife.in_lane_valid = '0;
    ife.out_ready = 1'b1; ife.wb_valid = 1'b0; ife.wb_addr = '0; ife.flush = 1'b0;

    // reset state
    #12;
    chk("rst.in_ready",   32'(ifa.in_ready), 32'd0);
    chk("rst.out_valid",  32'(ifa.out_valid), 32'd0);
    chk("rst.out_rd",     32'(ifa.out_rd_addr), 32'd0);
    chk("rst.sb",         32'(dut.sb_q), 32'd0);
    chk("rst.e.in_ready", 32'(ife.in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // add a0,a1,a2 on lane0; lane1 invalid with garbage
    drive(32'hFFFF_FFFF, 32'h00C5_8533, 2'b00, 2'b01);
    #1 chk("add.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(0, 0, 0, 10, 11, 12, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00));
    tick();
    pop_out("add");
    chk("add.sb", 32'(dut.sb_q), 32'h0000_0400);

    // addi a1,a0,1 must stall on a0
    drive(32'h0, 32'h0015_0593, 2'b00, 2'b01);
    #1 chk("raw.in_ready", 32'(ifa.in_ready), 32'd0);
    tick();
    chk("raw.out_valid_drained", 32'(ifa.out_valid), 32'd0);
    chk("raw.in_ready_hold", 32'(ifa.in_ready), 32'd0);
    ifa.wb_valid = 1'b1; ifa.wb_addr = 5'd10;
    #1 chk("wb.no_bypass", 32'(ifa.in_ready), 32'd0);
    tick();
    ifa.wb_valid = 1'b0;
    #1 chk("wb.in_ready_next", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(0, 0, 0, 11, 10, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00));
    tick();
    pop_out("addi");
    chk("addi.sb", 32'(dut.sb_q), 32'h0000_0800);

    // RVC c.lw a0,0(a1) + c.mv a0,a1
    idle();
    wb(5'd11);
    drive(32'h0000_852E, 32'h0000_4188, 2'b11, 2'b11);
    #1 chk("rvc1.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(10, 0, 11, 10, 11, 0, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00));
    tick();
    pop_out("rvc_lw_mv");
    chk("rvc1.sb", 32'(dut.sb_q), 32'h0000_0400);

    // RVC c.add a0,a1 + c.swsp a0 (lane1 reads lane0 rd)
    idle();
    wb(5'd10);
    drive(32'h0000_C02A, 32'h0000_952E, 2'b11, 2'b11);
    #1 chk("rvc2.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(0, 2, 10, 10, 10, 11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00));
    tick();
    pop_out("rvc_add_swsp");

    // 32-bit intra RAW bundle, then downstream backpressure for 3 cycles
    idle();
    wb(5'd10);
    ifa.out_ready = 1'b0;
    drive(32'h0015_0593, 32'h00C5_8533, 2'b00, 2'b11);
    #1 chk("b4.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(11, 10, 1, 10, 11, 12, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00));
    tick();
    drive(32'h0, 32'h0000_0337, 2'b00, 2'b01);  // lui x6: no hazard
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.in_ready", 32'(ifa.in_ready), 32'd0);
      chk("stall.out_valid", 32'(ifa.out_valid), 32'd1);
      cmp_out("stall", q[0]);
      tick();
    end
    ifa.out_ready = 1'b1;
    #1 chk("release.in_ready", 32'(ifa.in_ready), 32'd1);
    pop_out("b4_drain");
    q.push_back(mk(0, 0, 0, 6, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tick();
    pop_out("lui6");

    // set beats same-cycle retire of the same register
    drive(32'h0, 32'h0000_02B7, 2'b00, 2'b01);  // lui x5
    ifa.wb_valid = 1'b1; ifa.wb_addr = 5'd5;
    #1 chk("setwin.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(0, 0, 0, 5, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    tick();
    ifa.wb_valid = 1'b0;
    pop_out("lui5");
    chk("setwin.sb", 32'(dut.sb_q), 32'h0000_0C60);

    // flush with concurrent wb and a hazard-free bundle offered
    drive(32'h0, 32'h0000_03B7, 2'b00, 2'b01);  // lui x7
    ifa.flush = 1'b1; ifa.wb_valid = 1'b1; ifa.wb_addr = 5'd5;
    #1 chk("flush.in_ready", 32'(ifa.in_ready), 32'd0);
    tick();
    ifa.flush = 1'b0; ifa.wb_valid = 1'b0;
    idle();
    chk("flush.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("flush.sb", 32'(dut.sb_q), 32'd0);

    // async reset in the middle of a stall
    ifa.out_ready = 1'b0;
    drive(32'h0, 32'h00C5_8533, 2'b00, 2'b01);
    #1 chk("pre_rst.in_ready", 32'(ifa.in_ready), 32'd1);
    q.push_back(mk(0, 0, 0, 10, 11, 12, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00));
    tick();
    pop_out("add_pre_rst");
    drive(32'h0, 32'h0015_0593, 2'b00, 2'b01);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(ifa.out_valid), 32'd0);
    chk("arst.sb",        32'(dut.sb_q), 32'd0);
    chk("arst.in_ready",  32'(ifa.in_ready), 32'd0);
    chk("arst.out_rd",    32'(ifa.out_rd_addr), 32'd0);
    idle();
    ifa.out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // RV32E: add x20,x1,x2 (illegal) + add x3,x1,x2
    ife.in_valid = 1'b1;
    ife.in_instr = {32'h0020_81B3, 32'h0020_8A33};
    ife.in_compressed = 2'b00;
    ife.in_lane_valid = 2'b11;
    #1 chk("e.in_ready", 32'(ife.in_ready), 32'd1);
    tick();
    ife.in_valid = 1'b0; ife.in_lane_valid = 2'b00;
    chk("e.out_valid", 32'(ife.out_valid), 32'd1);
    chk("e.illegal",   32'(ife.out_illegal_reg), 32'd1);
    chk("e.rd",        32'(ife.out_rd_addr), 32'({5'd3, 5'd20}));
    chk("e.we",        32'(ife.out_rd_we), 32'd3);
    chk("e.sb",        32'(dut_e.sb_q), 32'h0000_0008);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_decoder_gpr_issue.md
Name: riscv_decoder_gpr_issue

Overview:
- Parametrised, registered successor of the single-lane combinational GPR address decoder.
- Each cycle it decodes up to NUM_LANES RV32 or RVC instructions into rd/rs1/rs2 addresses plus write-enable and source-used flags.
- It tracks in-flight destination registers in a scoreboard, stalls issue on RAW hazards, and presents results through a valid/ready output register.
- It sits between fetch/align and the operand-read/issue stage.

Parameters:
- NUM_LANES, 2, instructions decoded per bundle (legal range 1..4).
- NUM_GPR, 32, architectural registers; 16 selects RV32E.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bundle present.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_instr  in  32*NUM_LANES  lane k at bits [32k+31:32k]; RVC uses the low 16 bits.
- in_compressed  in  NUM_LANES  lane k is RVC.
- in_lane_valid  in  NUM_LANES  lane k carries an instruction.
- out_valid  out  1  decoded bundle held.
- out_ready  in  1  downstream accepts.
- out_rd_addr, out_rs1_addr, out_rs2_addr  out  5*NUM_LANES  decoded addresses.
- out_rd_we  out  NUM_LANES  lane writes rd (never for x0).
- out_rs1_used, out_rs2_used  out  NUM_LANES  source operand read.
- out_lane_valid  out  NUM_LANES  registered copy of in_lane_valid.
- out_intra_raw  out  NUM_LANES  lane k reads the rd of a lower lane in the same bundle.
- out_illegal_reg  out  NUM_LANES  an address ≥ NUM_GPR is used (RV32E).
- wb_valid  in  1  writeback retire.
- wb_addr  in  5  register being retired.
- flush  in  1  pipeline flush.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0 and every out_* register=0.
  - Scoreboard cleared to 0.
  - in_ready=0 while rst_n=0.
- 32-bit decode:
  - rd=[11:7], rs1=[19:15], rs2=[24:20].
  - rd_we=0 for BRANCH, STORE, MISC-MEM and SYSTEM funct3=0 opcodes; otherwise rd_we=(rd!=0).
  - rs1_used=0 for LUI, AUIPC and JAL.
  - rs2_used=1 only for OP, STORE, BRANCH and AMO.
- RVC decode, with c_42={01,[9:7]}, c_97={01,[4:2]}, c_62=[6:2]:
  - C.LW: rd=c_97, rs1=c_42.
  - C.SW: rs1=c_42, rs2=c_97.
  - C.ADDI4SPN: rd=c_97, rs1=x2.
  - C.J: rd=x0.
  - C.JAL: rd=x1.
  - C.JR: rs1=[11:7], rd=x0.
  - C.JALR: rs1=[11:7], rd=x1.
  - C.BEQZ/C.BNEZ: rs1=c_42.
  - C.SRLI/C.SRAI/C.ANDI: rd=rs1=c_42.
  - C.SUB/C.XOR/C.OR/C.AND: rd=rs1=c_42, rs2=c_97.
  - C.ADDI/C.SLLI: rs1=rd=[11:7].
  - C.LI: rs1=x0.
  - C.ADDI16SP: rd=rs1=x2.
  - C.LWSP: rs1=x2.
  - C.SWSP: rs1=x2, rs2=c_62.
  - C.MV: rs1=x0, rs2=c_62.
  - C.ADD: rs1=rd, rs2=c_62.
  - C.EBREAK and C.NOP: rd_we=0.
  - Any unlisted field reads 0.
  - RVC rd_we and *_used follow the operation semantics; x0 is never "used".
- Invalid lanes (in_lane_valid[k]=0): all addresses and flags forced to 0.
- Scoreboard:
  - NUM_GPR bits; bit 0 is hard-wired 0.
  - On acceptance, set the bit for every lane with rd_we.
  - On wb_valid, clear sb[wb_addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - wb_addr ≥ NUM_GPR is ignored.
- Hazard:
  - Asserted if any valid lane has a used source, or an rd_we destination (WAW), whose scoreboard bit is set.
  - Evaluated from the registered scoreboard only; there is no writeback bypass, so in_ready rises the cycle after wb_valid.
  - Intra-bundle dependencies do not stall; they are reported on out_intra_raw.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Latency is 1 cycle: an accepted bundle appears with out_valid=1 on the next edge.
  - The output register holds stable while out_valid && !out_ready.
  - When out_valid && out_ready && !accept, out_valid clears.
- Flush:
  - Synchronous. Clears out_valid and the whole scoreboard.
  - No acceptance occurs in the flush cycle.
  - wb_valid is ignored in that cycle.
- out_illegal_reg: set when NUM_GPR=16 and any used or written address has bit 4 set. Decode still proceeds.

Test Plan:
- Lane0 0x00C58533 (add a0,a1,a2), 32-bit -> next cycle out_rd=10, rs1=11, rs2=12, rd_we=1, both used=1, sb[10]=1.
- Lane0 RVC 0x4188 (c.lw a0,0(a1)) plus lane1 RVC 0x852E (c.mv a0,a1) -> lane0 rd=10 rs1=11 rs2_used=0; lane1 rd=10 rs1=0 rs2=11; out_intra_raw=00, the WAW is intra-bundle and allowed.
- Accept add a0; then present 0x00150593 (addi a1,a0,1) -> in_ready=0. Pulse wb_valid, wb_addr=10 -> in_ready=1 the following cycle and the bundle is accepted.
- Hold out_ready=0 for 3 cycles with a new in_valid -> outputs stable, in_ready=0. Raise out_ready -> new bundle latched one cycle later.
- Set sb[10], then flush=1 together with wb_valid=1 to x5 -> out_valid=0, scoreboard all 0, nothing accepted that cycle.
- NUM_GPR=16, add x20,x1,x2 -> out_illegal_reg[0]=1. Also assert rst_n low mid-stall -> out_valid=0 and scoreboard=0 immediately, asynchronously.
